// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, the fetch slot
// and the default reset vector.
package ifu_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request pending on imem
    ST_WAIT = 2'd1,  // request accepted, awaiting response
    ST_HOLD = 2'd2   // instruction held for decode
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_slot_t;

  // Sequential PC wraps naturally at 2^32 through the 32-bit add.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc,
                                                input logic        taken,
                                                input logic [31:0] target);
    return taken ? target : pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one imem request at a
// time, holds the returned word for decode and handles EX redirects.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  output logic [31:0] if_pc,
  input  logic        predict_taken,
  input  logic [31:0] predict_target,

  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,

  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_target,

  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_pc,

  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         stale_q, stale_d;
  fetch_slot_t  slot_q, slot_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic [31:0]  flush_count_q, flush_count_d;
  logic         id_fire;

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    stale_d        = stale_q;
    slot_d         = slot_q;
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    id_fire        = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          if (ex_redirect_valid) begin
            // Accepted request belongs to the flushed path: its response is dropped.
            stale_d = 1'b1;
          end else begin
            slot_d.pc          = pc_q;
            slot_d.pred_taken  = predict_taken;
            slot_d.pred_target = predict_target;
            pc_d               = next_fetch_pc(pc_q, predict_taken, predict_target);
          end
        end
      end

      ST_WAIT: begin
        if (imem_resp_valid) begin
          slot_d.inst = imem_resp_inst;
          stale_d     = 1'b0;
          state_d     = (stale_q || ex_redirect_valid) ? ST_REQ : ST_HOLD;
        end else if (ex_redirect_valid) begin
          stale_d = 1'b1;
        end
      end

      ST_HOLD: begin
        id_valid = 1'b1;
        if (ex_redirect_valid) begin
          state_d = ST_REQ;
        end else if (id_ready) begin
          id_fire = 1'b1;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_REQ;
    endcase

    if (ex_redirect_valid) begin
      pc_d = ex_redirect_pc;
    end

    fetch_count_d = fetch_count_q + {31'd0, id_fire};
    flush_count_d = flush_count_q + {31'd0, ex_redirect_valid};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      stale_q       <= 1'b0;
      slot_q        <= '0;
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      stale_q       <= stale_d;
      slot_q        <= slot_d;
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign if_pc          = pc_q;
  assign imem_req_addr  = pc_q;
  assign id_pc          = slot_q.pc;
  assign id_inst        = slot_q.inst;
  assign id_pred_taken  = slot_q.pred_taken;
  assign id_pred_target = slot_q.pred_target;
  assign fetch_count    = fetch_count_q;
  assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: stimulus pushes expected fetches into a
// scoreboard; a monitor pops and compares on every decode handshake.
module tb_ifu_fetch_ctrl;
  import ifu_fetch_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        ex_redirect_valid;
  logic [31:0] ex_redirect_pc;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  int          tests;
  int          fails;
  int          hs_seen;
  logic [31:0] flush_exp;
  fetch_slot_t sb[$];

  bit          bp_en;
  logic [31:0] bp_pc;
  logic [31:0] bp_tgt;

  int          mem_lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  ifu_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_inst   (imem_resp_inst),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_pc            (id_pc),
    .id_inst          (id_inst),
    .id_pred_taken    (id_pred_taken),
    .id_pred_target   (id_pred_target),
    .ex_redirect_valid(ex_redirect_valid),
    .ex_redirect_pc   (ex_redirect_pc),
    .fetch_count      (fetch_count),
    .flush_count      (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peer branch predictor: a single programmable taken entry.
  assign predict_taken  = bp_en && (if_pc == bp_pc);
  assign predict_target = bp_tgt;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0F96;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction memory: one response mem_lat cycles after each accepted request.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_inst  = '0;
    mem_busy        = 1'b0;
    mem_cnt         = 0;
    mem_addr        = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_inst  = inst_of(mem_addr);
          mem_busy        = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if (!reset && imem_req_valid && imem_req_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = mem_lat - 1;
      end
    end
  end

  // Monitor: every decode handshake must match the head of the scoreboard.
  initial begin
    fetch_slot_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && id_valid && id_ready && !ex_redirect_valid) begin
        hs_seen++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_delivery: got id_pc 0x%08h, expected no delivery", id_pc);
        end else begin
          e = sb.pop_front();
          check("id_pc", id_pc, e.pc);
          check("id_inst", id_inst, e.inst);
          check("id_pred_taken", 32'(id_pred_taken), 32'(e.pred_taken));
          check("id_pred_target", id_pred_target, e.pred_target);
        end
      end
    end
  end

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, got imem_req_valid 0, expected 1", name);
    end
  endtask

  task automatic wait_id_valid(input string name);
    int n = 0;
    while (!id_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!id_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, got id_valid 0, expected 1", name);
    end
  endtask

  // Accept exactly one request at the expected address; optionally expect delivery.
  task automatic issue(input string name, input logic [31:0] pc, input bit deliver);
    fetch_slot_t e;
    wait_req(name);
    check({name, "_addr"}, imem_req_addr, pc);
    e.pc          = pc;
    e.inst        = inst_of(pc);
    e.pred_taken  = bp_en && (pc == bp_pc);
    e.pred_target = bp_tgt;
    if (deliver) sb.push_back(e);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    ex_redirect_valid = 1'b1;
    ex_redirect_pc    = pc;
    flush_exp++;
    @(negedge clk);
    ex_redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0;
    bit stable;
    tests             = 0;
    fails             = 0;
    hs_seen           = 0;
    flush_exp         = '0;
    reset             = 1'b1;
    imem_req_ready    = 1'b0;
    id_ready          = 1'b1;
    ex_redirect_valid = 1'b0;
    ex_redirect_pc    = '0;
    bp_en             = 1'b0;
    bp_pc             = '0;
    bp_tgt            = '0;
    mem_lat           = 1;

    repeat (3) @(negedge clk);
    check("rst_if_pc", if_pc, 32'h8000_0000);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_flush_count", flush_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h8000_0000);

    // Sequential not-taken fetches with 1-cycle memory.
    issue("seq0", 32'h8000_0000, 1'b1); wait_req("seq0_done");
    issue("seq1", 32'h8000_0004, 1'b1); wait_req("seq1_done");
    issue("seq2", 32'h8000_0008, 1'b1); wait_req("seq2_done");
    check("seq_fetch_count", fetch_count, 32'd3);

    // Predicted-taken at 0x80000004.
    redirect(32'h8000_0004);
    bp_en  = 1'b1;
    bp_pc  = 32'h8000_0004;
    bp_tgt = 32'h8000_0100;
    issue("bp_pc", 32'h8000_0004, 1'b1);
    wait_req("bp_done");
    check("bp_next_addr", imem_req_addr, 32'h8000_0100);
    bp_en  = 1'b0;
    bp_tgt = '0;
    issue("bp_tgt_fetch", 32'h8000_0100, 1'b1); wait_req("bp_tgt_done");

    // Redirect in WAIT, response 3 cycles later is discarded.
    mem_lat = 4;
    issue("stale", 32'h8000_0104, 1'b0);
    redirect(32'h8000_0200);
    check("stale_still_waiting", 32'(imem_req_valid), 32'd0);
    wait_req("stale_done");
    check("stale_next_addr", imem_req_addr, 32'h8000_0200);
    check("stale_flush_count", flush_count, flush_exp);
    mem_lat = 1;
    issue("post_stale", 32'h8000_0200, 1'b1); wait_req("post_stale_done");

    // Redirect coinciding with the response in WAIT.
    mem_lat = 2;
    issue("resp_redir", 32'h8000_0204, 1'b0);
    @(negedge clk);
    redirect(32'h8000_0300);
    wait_req("resp_redir_done");
    mem_lat = 1;
    issue("after_resp_redir", 32'h8000_0300, 1'b1); wait_req("after_resp_redir_done");

    // Redirect in REQ coinciding with acceptance.
    wait_req("redir_accept");
    imem_req_ready    = 1'b1;
    ex_redirect_valid = 1'b1;
    ex_redirect_pc    = 32'h8000_0400;
    flush_exp++;
    @(negedge clk);
    imem_req_ready    = 1'b0;
    ex_redirect_valid = 1'b0;
    check("redir_accept_in_wait", 32'(imem_req_valid), 32'd0);
    wait_req("redir_accept_done");
    issue("after_redir_accept", 32'h8000_0400, 1'b1); wait_req("after_redir_accept_done");

    // Redirect in HOLD with id_ready=1 in the same cycle.
    id_ready = 1'b0;
    issue("hold_redir", 32'h8000_0404, 1'b0);
    wait_id_valid("hold_redir_hold");
    hs0      = hs_seen;
    id_ready = 1'b1;
    redirect(32'h8000_0600);
    check("hold_redir_id_valid", 32'(id_valid), 32'd0);
    check("hold_redir_fetch_count", fetch_count, 32'(hs0));
    issue("after_hold_redir", 32'h8000_0600, 1'b1); wait_req("after_hold_redir_done");

    // Decode stall for 10 cycles in HOLD.
    id_ready = 1'b0;
    issue("stall", 32'h8000_0604, 1'b1);
    wait_id_valid("stall_hold");
    hs0    = hs_seen;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!id_valid || imem_req_valid || id_pc !== 32'h8000_0604 ||
          id_inst !== inst_of(32'h8000_0604) || fetch_count !== 32'(hs0))
        stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    id_ready = 1'b1;
    wait_req("stall_release");
    check("stall_fetch_count", fetch_count, 32'(hs0 + 1));

    // Sequential PC wraps past 0xFFFFFFFC.
    redirect(32'hFFFF_FFFC);
    issue("wrap", 32'hFFFF_FFFC, 1'b1); wait_req("wrap_done");
    issue("wrap_next", 32'h0000_0000, 1'b1); wait_req("wrap_next_done");
    check("pre_rst_flush_count", flush_count, flush_exp);

    // Reset mid-WAIT; the late response must be ignored.
    mem_lat = 3;
    issue("rst_wait", 32'h0000_0004, 1'b0);
    reset     = 1'b1;
    hs_seen   = 0;
    flush_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_if_pc", if_pc, 32'h8000_0000);
    check("rst2_fetch_count", fetch_count, 32'd0);
    check("rst2_flush_count", flush_count, 32'd0);
    repeat (4) @(negedge clk);
    check("rst2_late_resp_id_valid", 32'(id_valid), 32'd0);
    check("rst2_req_valid", 32'(imem_req_valid), 32'd1);
    mem_lat = 1;
    issue("post_rst", 32'h8000_0000, 1'b1); wait_req("post_rst_done");
    check("post_rst_fetch_count", fetch_count, 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
